icewerxadc_scheduler: RTL and testbench

// Polls the 4-channel icewerx serial ADC over a byte-level UART interface.

---
 rtl/icewerxadc_scheduler.sv | 173 +++++++++++++++++
 tb/tb_icewerxadc_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icewerxadc_scheduler.sv
// rtl/icewerxadc_scheduler.sv - round-robin poller for the 4-channel icewerx serial ADC
// Sends one command byte per poll slot and publishes the 10-bit little-endian reply.
module icewerxadc_scheduler #(
  parameter int unsigned ClkFrequency  = 12000000,
  parameter int unsigned PollHz        = 400,
  parameter int unsigned TimeoutCycles = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] enable_mask,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_eop,
  output logic [9:0] adc1,
  output logic [9:0] adc2,
  output logic [9:0] adc3,
  output logic [9:0] adc4,
  output logic [3:0] adc_valid,
  output logic [3:0] adc_error,
  output logic       overrun
);

  localparam int unsigned Interval = ClkFrequency / PollHz;
  localparam int unsigned SlotW    = (Interval > 1) ? $clog2(Interval) : 1;
  localparam int unsigned TmoW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(Interval - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [1:0]       last_ch_q, last_ch_d;
  logic [1:0]       ch_q, ch_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic [15:0]      buf_q, buf_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [9:0]       adc_q [4];
  logic [9:0]       adc_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       error_q, error_d;
  logic             overrun_q, overrun_d;

  logic             tick;
  logic [1:0]       pick;
  logic [1:0]       idx;

  assign tick = (slot_q == SlotLast);

  // Scan from the farthest candidate to the nearest so the first enabled channel after last_ch wins.
  always_comb begin
    pick = last_ch_q;
    idx  = last_ch_q;
    for (int i = 4; i >= 1; i--) begin
      idx = last_ch_q + 2'(i);
      if (enable_mask[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = tick ? '0 : slot_q + SlotW'(1);
    tmo_d      = tmo_q;
    last_ch_d  = last_ch_q;
    ch_d       = ch_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    adc_d      = adc_q;
    valid_d    = valid_q & enable_mask;
    error_d    = error_q;
    overrun_d  = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (tick && (enable_mask != 4'd0)) begin
          ch_d      = pick;
          last_ch_d = pick;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tick) overrun_d = 1'b1;
        if (!tx_busy) begin
          tx_data_d  = 8'hA1 + {6'd0, ch_q};
          tx_start_d = 1'b1;
          cnt_d      = 2'd0;
          buf_d      = 16'd0;
          tmo_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) overrun_d = 1'b1;
        tmo_d = tmo_q + TmoW'(1);
        // End of packet outranks both a same-cycle byte and the timeout.
        if (rx_eop) begin
          if (cnt_q == 2'd2) begin
            adc_d[ch_q]   = buf_q[9:0];
            valid_d[ch_q] = 1'b1;
            error_d[ch_q] = 1'b0;
          end else begin
            error_d[ch_q] = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          if (rx_valid && (cnt_q < 2'd2)) begin
            buf_d = {rx_data, buf_q[15:8]};
            cnt_d = cnt_q + 2'd1;
          end
          if (tmo_q == TmoLast) begin
            error_d[ch_q] = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      tmo_q      <= '0;
      last_ch_q  <= 2'd3;
      ch_q       <= 2'd0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      buf_q      <= 16'd0;
      cnt_q      <= 2'd0;
      for (int i = 0; i < 4; i++) adc_q[i] <= 10'd0;
      valid_q    <= 4'd0;
      error_q    <= 4'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      tmo_q      <= tmo_d;
      last_ch_q  <= last_ch_d;
      ch_q       <= ch_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < 4; i++) adc_q[i] <= adc_d[i];
      valid_q    <= valid_d;
      error_q    <= error_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign adc1      = adc_q[0];
  assign adc2      = adc_q[1];
  assign adc3      = adc_q[2];
  assign adc4      = adc_q[3];
  assign adc_valid = valid_q;
  assign adc_error = error_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_icewerxadc_scheduler.sv
// tb/tb_icewerxadc_scheduler.sv - self-checking bench for icewerxadc_scheduler
// Drives an ADC reply model and compares every cycle against a slot/transaction model.
module tb_icewerxadc_scheduler;

  localparam int CLK_HZ  = 40000;
  localparam int POLL_HZ = 100;
  localparam int TMO     = 150;
  localparam int I       = CLK_HZ / POLL_HZ;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] enable_mask = 4'hF;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_eop = 1'b0;
  logic [9:0] adc1, adc2, adc3, adc4;
  logic [3:0] adc_valid, adc_error;
  logic       overrun;

  icewerxadc_scheduler #(
    .ClkFrequency (CLK_HZ),
    .PollHz       (POLL_HZ),
    .TimeoutCycles(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_mask(enable_mask),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_eop     (rx_eop),
    .adc1       (adc1),
    .adc2       (adc2),
    .adc3       (adc3),
    .adc4       (adc4),
    .adc_valid  (adc_valid),
    .adc_error  (adc_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] next_ch(input logic [1:0] last, input logic [3:0] m);
    for (int i = 1; i <= 4; i++)
      if (m[(int'(last) + i) % 4]) return 2'((int'(last) + i) % 4);
    return last;
  endfunction

  // Reference model: time counted in clock edges since reset release.
  bit         started = 0;
  int         cyc = 0;
  int         exp_start_edge = -1;
  logic [1:0] last_ch = 2'd3;
  logic [1:0] cur_ch = 2'd0;
  bit         active = 0;
  bit         sent = 0;
  bit         was_active;
  int         nbytes = 0;
  logic [7:0] rb [2];
  logic [9:0] exp_adc [4];
  logic [3:0] exp_valid = 4'd0;
  logic [3:0] exp_error = 4'd0;
  logic       exp_overrun = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      cyc = 0;
      exp_start_edge = -1;
      last_ch = 2'd3;
      active = 0;
      sent = 0;
      nbytes = 0;
      for (int i = 0; i < 4; i++) exp_adc[i] = 10'd0;
      exp_valid = 4'd0;
      exp_error = 4'd0;
      exp_overrun = 1'b0;
    end else begin
      cyc++;
      was_active = active;
      exp_valid = exp_valid & enable_mask;
      if (active && sent) begin
        if (rx_eop) begin
          if (nbytes == 2) begin
            exp_adc[cur_ch] = {rb[1][1:0], rb[0]};
            exp_valid[cur_ch] = 1'b1;
            exp_error[cur_ch] = 1'b0;
          end else begin
            exp_error[cur_ch] = 1'b1;
          end
          active = 0;
        end else begin
          if (rx_valid && nbytes < 2) begin
            rb[nbytes] = rx_data;
            nbytes++;
          end
          if (cyc - exp_start_edge == TMO) begin
            exp_error[cur_ch] = 1'b1;
            active = 0;
          end
        end
      end else if (active && !sent && !tx_busy) begin
        sent = 1;
        nbytes = 0;
        exp_start_edge = cyc;
      end
      if (cyc % I == 0) begin
        if (was_active) exp_overrun = 1'b1;
        else if (enable_mask != 4'd0) begin
          cur_ch = next_ch(last_ch, enable_mask);
          last_ch = cur_ch;
          active = 1;
          sent = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("adc1", adc1, exp_adc[0]);
      chk("adc2", adc2, exp_adc[1]);
      chk("adc3", adc3, exp_adc[2]);
      chk("adc4", adc4, exp_adc[3]);
      chk("adc_valid", adc_valid, exp_valid);
      chk("adc_error", adc_error, exp_error);
      chk("overrun", overrun, exp_overrun);
      chk("tx_start", tx_start, (cyc == exp_start_edge) ? 1 : 0);
      if (cyc == exp_start_edge) chk("tx_data", tx_data, 8'hA1 + cur_ch);
    end
  end

  task automatic wait_tx(output int lat);
    lat = 0;
    while (lat < 3 * I) begin
      @(negedge clk);
      lat++;
      if (tx_start) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_tx: no tx_start within %0d cycles", 3 * I);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < TMO + 10; n++) begin
      if (!active) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_idle: transaction still open after %0d cycles", TMO + 10);
  endtask

  // kind: 0 good, 1 short, 2 three bytes, 3 silent, 4 bare eop, 5 good+byte on eop, 6 short+byte on eop
  task automatic reply(input int kind, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] b [3];
    int nb;
    b[0] = b0;
    b[1] = b1;
    b[2] = b2;
    if (kind != 3) begin
      nb = (kind == 0 || kind == 5) ? 2 : (kind == 1 || kind == 6) ? 1 : (kind == 2) ? 3 : 0;
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rx_data = b[i];
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rx_eop = 1'b1;
      if (kind == 5 || kind == 6) begin
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
      end
      @(negedge clk);
      rx_eop = 1'b0;
      rx_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic hold_busy(input int n);
    tx_busy = 1'b1;
    for (int k = 0; k < 2 * I + 10 && !active; k++) @(negedge clk);
    repeat (n) @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_eop = 1'b0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] cmds [4];

    repeat (3) @(negedge clk);
    chk("rst_adc1", adc1, 0);
    chk("rst_valid", adc_valid, 0);
    chk("rst_error", adc_error, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tx_start", tx_start, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wait_tx(lat);
      cmds[i] = tx_data;
      reply(0, 8'h34, 8'h02, 8'h00);
    end
    for (int i = 0; i < 4; i++) chk("rr_cmd", cmds[i], 8'hA1 + i);
    chk("rr_adc1", adc1, 10'h234);
    chk("rr_adc2", adc2, 10'h234);
    chk("rr_adc3", adc3, 10'h234);
    chk("rr_adc4", adc4, 10'h234);
    chk("rr_valid", adc_valid, 4'hF);

    enable_mask = 4'b0101;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_tx(lat);
      cmds[i] = tx_data;
      reply(0, 8'h34, 8'h02, 8'h00);
    end
    for (int i = 0; i < 4; i++) chk("m5_cmd", cmds[i], (i % 2 == 0) ? 8'hA1 : 8'hA3);
    chk("m5_valid", adc_valid, 4'b0101);
    chk("m5_adc2", adc2, 10'h000);
    chk("m5_adc4", adc4, 10'h000);

    enable_mask = 4'hF;
    do_reset();
    wait_tx(lat);
    reply(0, 8'h34, 8'h02, 8'h00);
    wait_tx(lat);
    chk("sil_cmd", tx_data, 8'hA2);
    reply(3, 8'h00, 8'h00, 8'h00);
    chk("sil_err", adc_error[1], 1'b1);
    wait_tx(lat);
    chk("sil_next", tx_data, 8'hA3);
    reply(0, 8'h10, 8'h01, 8'h00);
    wait_tx(lat);
    reply(0, 8'h20, 8'h02, 8'h00);
    wait_tx(lat);
    reply(1, 8'h77, 8'h00, 8'h00);
    chk("short_err", adc_error[0], 1'b1);
    chk("short_hold", adc1, 10'h234);
    wait_tx(lat);
    reply(2, 8'hFF, 8'h03, 8'h55);
    chk("three_adc2", adc2, 10'h3FF);
    chk("three_err", adc_error[1], 1'b0);

    hold_busy(50);
    wait_tx(lat);
    chk("busy_lat", lat, 1);
    @(negedge clk);
    chk("busy_pulse", tx_start, 0);
    reply(0, 8'h55, 8'hFE, 8'h00);
    chk("busy_adc3", adc3, 10'h255);
    chk("pre_overrun", overrun, 0);

    hold_busy(I + 20);
    wait_tx(lat);
    reply(0, 8'h01, 8'h01, 8'h00);
    chk("overrun_set", overrun, 1);

    enable_mask = 4'h0;
    repeat (2 * I) @(negedge clk);
    chk("mask0_valid", adc_valid, 4'h0);
    enable_mask = 4'hF;

    for (int t = 0; t < 40; t++) begin
      wait_tx(lat);
      reply($urandom_range(0, 6), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) enable_mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) hold_busy($urandom_range(1, 40));
    end

    enable_mask = 4'hF;
    wait_tx(lat);
    rx_data = 8'h12;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_adc1", adc1, 0);
    chk("mid_adc3", adc3, 0);
    chk("mid_valid", adc_valid, 0);
    chk("mid_error", adc_error, 0);
    chk("mid_overrun", overrun, 0);
    wait_tx(lat);
    chk("mid_first_cmd", tx_data, 8'hA1);
    reply(0, 8'h34, 8'h02, 8'h00);
    chk("mid_adc1_after", adc1, 10'h234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
